// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock using a
// (WIDTH+1)-bit ripple-carry trial subtract (A + ~B + 1). Start/Ready/Valid
// handshake; divide-by-zero returns all-ones quotient and the dividend as
// remainder with single-cycle latency.
module seq_restoring_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Dividend,
    input  logic [WIDTH-1:0] Divisor,
    output logic             Ready,
    output logic             Valid,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             Div_By_Zero
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;        // partial remainder
    logic [WIDTH-1:0] q_q, q_d;        // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0] d_q, d_d;        // latched divisor
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   sub_a, sub_b, sub_t;
    logic [WIDTH+1:0] carry;
    logic             no_borrow;

    // Trial subtract {P, Q msb} - {0, D} as an explicit ripple-carry chain.
    always_comb begin
        sub_a    = {p_q, q_q[WIDTH-1]};
        sub_b    = ~{1'b0, d_q};
        sub_t    = '0;
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i <= WIDTH; i++) begin
            sub_t[i]     = sub_a[i] ^ sub_b[i] ^ carry[i];
            carry[i + 1] = (sub_a[i] & sub_b[i]) | (sub_a[i] & carry[i]) |
                           (sub_b[i] & carry[i]);
        end
        no_borrow = carry[WIDTH + 1];
    end

    // Next-state and datapath update; result registers change only on entry to DONE.
    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle, StDone: begin
                state_d = StIdle;
                if (Start) begin
                    if (Divisor != '0) begin
                        d_d     = Divisor;
                        p_d     = '0;
                        q_d     = Dividend;
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        quo_d   = '1;
                        rem_d   = Dividend;
                        dbz_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                if (no_borrow) begin
                    p_d = sub_t[WIDTH-1:0];
                    q_d = {q_q[WIDTH-2:0], 1'b1};
                end else begin
                    p_d = {p_q[WIDTH-2:0], q_q[WIDTH-1]};
                    q_d = {q_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LastCnt) begin
                    quo_d   = q_d;
                    rem_d   = p_d;
                    dbz_d   = 1'b0;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Ready       = (state_q != StRun);
    assign Valid       = (state_q == StDone);
    assign Quotient    = quo_q;
    assign Remainder   = rem_q;
    assign Div_By_Zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomised checks of seq_restoring_divider at WIDTH=32.
module tb_seq_restoring_divider;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         Start;
    logic [W-1:0] Dividend;
    logic [W-1:0] Divisor;
    logic         Ready;
    logic         Valid;
    logic [W-1:0] Quotient;
    logic [W-1:0] Remainder;
    logic         Div_By_Zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .Start       (Start),
        .Dividend    (Dividend),
        .Divisor     (Divisor),
        .Ready       (Ready),
        .Valid       (Valid),
        .Quotient    (Quotient),
        .Remainder   (Remainder),
        .Div_By_Zero (Div_By_Zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Steps edges until Valid (bounded). Inputs change #1 after each edge.
    task automatic wait_valid(input bit hold, input bit scramble, output int cycles,
                              output bit ready_bad);
        cycles    = 0;
        ready_bad = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
            if (!hold) Start = 1'b0;
            if (!Valid && Ready) ready_bad = 1'b1;
            if (scramble) begin
                Dividend = $urandom;
                Divisor  = $urandom;
            end
        end while (!Valid && cycles < 100);
        if (!Valid) check("timeout", 64'(cycles), 64'd0);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int cycles,
                          output bit ready_bad);
        Start    = 1'b1;
        Dividend = a;
        Divisor  = b;
        wait_valid(1'b0, 1'b0, cycles, ready_bad);
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] q, input logic [W-1:0] r,
                                input logic dbz);
        check({tag, "_q"}, 64'(Quotient), 64'(q));
        check({tag, "_r"}, 64'(Remainder), 64'(r));
        check({tag, "_dbz"}, 64'(Div_By_Zero), 64'(dbz));
    endtask

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 4))
            0:       v = '0;
            1:       v = 1;
            2:       v = '1;
            3:       v = W'(1) << $urandom_range(0, W - 1);
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int           cyc;
        bit           rbad;
        bit           stale;
        logic [W-1:0] a, b;
        logic [63:0]  recon;

        rst      = 1'b1;
        Start    = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        Start = 1'b1;  // rst must win over Start
        @(posedge clk);
        #1;
        rst   = 1'b0;
        Start = 1'b0;
        check("rst_ready", 64'(Ready), 64'd1);
        check("rst_valid", 64'(Valid), 64'd0);
        check_result("rst", '0, '0, 1'b0);

        // 100 / 7
        run_op(32'd100, 32'd7, cyc, rbad);
        check("t1_latency", 64'(cyc), 64'd33);
        check("t1_ready_busy", 64'(rbad), 64'd0);
        check("t1_ready_done", 64'(Ready), 64'd1);
        check_result("t1", 32'd14, 32'd2, 1'b0);
        @(posedge clk);
        #1;
        check("t1_valid_pulse", 64'(Valid), 64'd0);
        check("t1_hold_q", 64'(Quotient), 64'd14);

        // Boundary operands
        run_op(32'hFFFF_FFFF, 32'd1, cyc, rbad);
        check_result("t2a", 32'hFFFF_FFFF, 32'd0, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, rbad);
        check_result("t2b", 32'd1, 32'd0, 1'b0);
        run_op(32'd5, 32'd9, cyc, rbad);
        check_result("t2c", 32'd0, 32'd5, 1'b0);
        run_op(32'd0, 32'd3, cyc, rbad);
        check("t2d_latency", 64'(cyc), 64'd33);
        check_result("t2d", 32'd0, 32'd0, 1'b0);

        // Divide by zero, then a normal op clears the flag
        run_op(32'h1234, 32'd0, cyc, rbad);
        check("t3_latency", 64'(cyc), 64'd1);
        check_result("t3a", 32'hFFFF_FFFF, 32'h1234, 1'b1);
        run_op(32'd8, 32'd2, cyc, rbad);
        check_result("t3b", 32'd4, 32'd0, 1'b0);

        // Start held high with churning operands; back-to-back accept in DONE
        Start    = 1'b1;
        Dividend = 32'd1000;
        Divisor  = 32'd10;
        wait_valid(1'b1, 1'b1, cyc, rbad);
        check("t4_latency", 64'(cyc), 64'd33);
        check_result("t4a", 32'd100, 32'd0, 1'b0);
        Dividend = 32'd77;
        Divisor  = 32'd5;
        wait_valid(1'b0, 1'b1, cyc, rbad);
        check("t4_b2b_latency", 64'(cyc), 64'd33);
        check_result("t4b", 32'd15, 32'd2, 1'b0);

        // Reset mid-run aborts with no later Valid
        Start    = 1'b1;
        Dividend = 32'd999;
        Divisor  = 32'd4;
        @(posedge clk);
        #1;
        Start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("t5_ready", 64'(Ready), 64'd1);
        check("t5_valid", 64'(Valid), 64'd0);
        check_result("t5", '0, '0, 1'b0);
        stale = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (Valid) stale = 1'b1;
        end
        check("t5_no_stale_valid", 64'(stale), 64'd0);

        // Random operands with corner-value bias
        for (int k = 0; k < 1000; k++) begin
            a = pick();
            b = pick();
            run_op(a, b, cyc, rbad);
            if (b == '0) begin
                check_result("rnd_dbz", '1, a, 1'b1);
            end else begin
                check_result("rnd", a / b, a % b, 1'b0);
                recon = 64'(Quotient) * 64'(b) + 64'(Remainder);
                check("rnd_inv", recon, 64'(a));
                check("rnd_rem_lt", 64'(Remainder < b), 64'd1);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
